// File: rtl/rf_tag_ctrl.sv
// Per-register write tracking for x1-x31: rolling write tags, dirty flags and
// in-flight counters feeding the operand bypass compare and the issue stall.
module rf_tag_ctrl #(
  parameter int TAG_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 issue_en,
  input  logic [4:0]           issue_rd_addr,
  output logic [TAG_WIDTH-1:0] issue_tag,
  output logic                 issue_ready,
  input  logic                 wb_en,
  input  logic [4:0]           wb_addr,
  input  logic [TAG_WIDTH-1:0] wb_tag,
  input  logic                 rd_rf1_en,
  input  logic [4:0]           rd_rf1_addr,
  output logic [TAG_WIDTH-1:0] rd_rf1_tag,
  output logic                 rd_rf1_dirty,
  input  logic                 rd_rf2_en,
  input  logic [4:0]           rd_rf2_addr,
  output logic [TAG_WIDTH-1:0] rd_rf2_tag,
  output logic                 rd_rf2_dirty,
  output logic                 any_pending
);

  localparam logic [TAG_WIDTH-1:0] CNT_MAX = '1;

  // Entry 0 is held at reset value so x0 never carries state.
  logic [TAG_WIDTH-1:0] tag_q   [32];
  logic [TAG_WIDTH-1:0] cnt_q   [32];
  logic [31:0]          dirty_q;

  logic issue_rd_nz;
  logic wb_addr_nz;
  logic issue_fire;
  logic wb_fire;

  assign issue_rd_nz = (issue_rd_addr != 5'd0);
  assign wb_addr_nz  = (wb_addr != 5'd0);

  assign issue_tag   = issue_rd_nz ? (tag_q[issue_rd_addr] + TAG_WIDTH'(1)) : '0;
  assign issue_ready = ~flush & (~issue_rd_nz | (cnt_q[issue_rd_addr] != CNT_MAX));

  assign issue_fire  = issue_en & issue_ready & issue_rd_nz;
  // A retire with nothing in flight is dropped rather than underflowing the counter.
  assign wb_fire     = wb_en & wb_addr_nz & (cnt_q[wb_addr] != '0);

  assign rd_rf1_tag   = (rd_rf1_en && rd_rf1_addr != 5'd0) ? tag_q[rd_rf1_addr] : '0;
  assign rd_rf1_dirty = rd_rf1_en && rd_rf1_addr != 5'd0 && dirty_q[rd_rf1_addr];
  assign rd_rf2_tag   = (rd_rf2_en && rd_rf2_addr != 5'd0) ? tag_q[rd_rf2_addr] : '0;
  assign rd_rf2_dirty = rd_rf2_en && rd_rf2_addr != 5'd0 && dirty_q[rd_rf2_addr];

  always_comb begin
    any_pending = 1'b0;
    for (int r = 1; r < 32; r++) begin
      if (cnt_q[r] != '0) any_pending = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dirty_q <= '0;
      for (int r = 0; r < 32; r++) begin
        tag_q[r] <= '0;
        cnt_q[r] <= '0;
      end
    end else if (flush) begin
      // Tags survive a flush so stale in-flight tags cannot alias new ones.
      dirty_q <= '0;
      for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (issue_fire && issue_rd_addr == 5'(r)) begin
          tag_q[r]   <= issue_tag;
          dirty_q[r] <= 1'b1;
          if (!(wb_fire && wb_addr == 5'(r))) cnt_q[r] <= cnt_q[r] + TAG_WIDTH'(1);
        end else if (wb_fire && wb_addr == 5'(r)) begin
          cnt_q[r] <= cnt_q[r] - TAG_WIDTH'(1);
          if (wb_tag == tag_q[r]) dirty_q[r] <= 1'b0;
        end
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst && !flush) begin
      assert (!(wb_en && wb_addr_nz && cnt_q[wb_addr] == '0))
        else $error("rf_tag_ctrl: writeback to x%0d with no write in flight", wb_addr);
    end
  end
`endif

endmodule

// File: doc/rf_tag_ctrl.md
Name: rf_tag_ctrl

Overview:
Per-register write-tracking controller for the integer register file (x0-x31). At issue it allocates a rolling write tag for the destination register, marks the register dirty and counts the in-flight write. At writeback it retires the tag. It supplies the dirty/tag pair that the operand bypass logic compares against the EX/MEM/WB forward tags, and it stalls issue when a register's tag space is exhausted.

Parameters:
TAG_WIDTH, 2, width of the per-register write tag; at most 2^TAG_WIDTH-1 writes per register may be in flight.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
flush  input  1  pipeline flush; kills all in-flight writes
issue_en  input  1  issue of an instruction that writes rd (qualified by issue_ready)
issue_rd_addr  input  5  destination register of issuing instruction
issue_tag  output  TAG_WIDTH  tag allocated to this write (valid when issue_en & issue_ready)
issue_ready  output  1  issue may proceed this cycle
wb_en  input  1  register write retiring
wb_addr  input  5  register being written back
wb_tag  input  TAG_WIDTH  tag carried by retiring write
rd_rf1_en  input  1  operand-1 lookup enable
rd_rf1_addr  input  5  operand-1 register
rd_rf1_tag  output  TAG_WIDTH  latest allocated tag of rd_rf1_addr
rd_rf1_dirty  output  1  rd_rf1_addr has a pending write with the latest tag
rd_rf2_en  input  1  operand-2 lookup enable
rd_rf2_addr  input  5  operand-2 register
rd_rf2_tag  output  TAG_WIDTH  latest allocated tag of rd_rf2_addr
rd_rf2_dirty  output  1  as rd_rf1_dirty, port 2
any_pending  output  1  OR of all inflight counters non-zero (used for fence/CSR drain)

Behaviour:
- State per register r (1..31): tag_q[r] (TAG_WIDTH), dirty_q[r] (1), cnt_q[r] (TAG_WIDTH, 0..2^TAG_WIDTH-1). x0 has no state: reads of x0 return tag 0 and dirty 0.
- Reset: all tag_q, dirty_q and cnt_q = 0; hence rd_rf*_dirty=0, rd_rf*_tag=0, any_pending=0, issue_ready=1, issue_tag=1.
- Lookups are combinational from registered state (pre-update value in the cycle of a same-register issue/wb). When rd_rf*_en=0, the outputs are tag 0 and dirty 0. Same-cycle WB data reaches the operand through the WB forward path, which matches on tag.
- issue_tag = tag_q[issue_rd_addr]+1 (mod 2^TAG_WIDTH), combinational.
- issue_ready = ~flush & (cnt_q[issue_rd_addr] != 2^TAG_WIDTH-1); always 1 for x0 unless flush.
- Issue accepted (issue_en & issue_ready, rd!=0): tag_q<=issue_tag, dirty_q<=1, cnt_q+1. For rd=0 there is no state change and issue_tag=0.
- Writeback (wb_en, wb_addr!=0): cnt_q-1. If wb_tag==tag_q[wb_addr], dirty_q<=0; otherwise dirty stays (a younger write is pending). wb to x0 is ignored.
- wb with cnt_q==0 is illegal: no state change, and a simulation assertion fires.
- Issue and wb to the same register in one cycle: cnt_q unchanged, tag_q<=issue_tag, dirty_q<=1. The wb tag compares against the old tag_q and cannot clear the new write.
- Issue and wb to different registers: both apply independently.
- flush: all dirty_q<=0 and cnt_q<=0. tag_q is retained, so stale tags still in flight cannot alias new allocations. Flush overrides issue and wb in the same cycle.
- any_pending is a combinational OR over cnt_q!=0.
- Reset asserted mid-operation returns all state to reset values immediately (asynchronous).

Test Plan:
- Reset then lookup x5 -> rd_rf1_dirty=0, tag=0. issue_en rd=5 -> issue_tag=1. Next cycle lookup x5 -> dirty=1, tag=1, any_pending=1.
- Issue x7 three times (tags 1,2,3) -> 4th issue to x7 sees issue_ready=0. wb x7 tag1 -> dirty stays 1, cnt=2, issue_ready=1.
- With x7 holding tags 1..3, wb tag2 then tag3 -> dirty=0 after the tag3 wb, cnt=0, any_pending=0.
- Same cycle: issue x9 (tag_q=1 -> 2) and wb x9 tag1 -> dirty=1, tag=2, cnt unchanged at 1.
- Issue x3, x4, then flush together with issue x10 -> all dirty=0, any_pending=0, x10 not allocated. Next issue x3 gets tag 2.
- Issue and wb to x0, lookup x0 -> issue_ready=1, issue_tag=0, dirty=0, any_pending unchanged. Assert rst mid-stream -> all outputs at reset values within the same cycle.
